neuron_sum_pipe: RTL and testbench

//   Parametrised, pipelined signed adder tree that reduces N_IN weighted neuron

---
 rtl/neuron_pkg.sv | 38 +++
 rtl/neuron_sum_pipe_level.sv | 37 +++
 rtl/neuron_sum_pipe.sv | 116 +++++++++++
 tb/tb_neuron_sum_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared width helper and saturating clamp used by the neuron summation
// pipeline and future accumulators.
package neuron_pkg;

    localparam int MAX_W = 128;

    typedef struct packed {
        logic [MAX_W-1:0] val;
        logic             sat;
    } clamp_t;

    function automatic int acc_w(input int n_in, input int in_w);
        return in_w + $clog2(n_in) + 1;
    endfunction

    // Clamp a sign-extended sum into the signed range of out_w bits.
    function automatic clamp_t sat_clamp(input logic signed [MAX_W-1:0] s,
                                         input int                      out_w);
        logic signed [MAX_W-1:0] lim;
        logic signed [MAX_W-1:0] max_v;
        logic signed [MAX_W-1:0] min_v;
        clamp_t                  r;
        lim   = MAX_W'(1) <<< (out_w - 1);
        max_v = lim - 1;
        min_v = -lim;
        r.val = s;
        r.sat = 1'b0;
        if (s > max_v) begin
            r.val = max_v;
            r.sat = 1'b1;
        end else if (s < min_v) begin
            r.val = min_v;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_sum_pipe_level.sv
// One registered adder-tree level: sums adjacent leaf pairs and carries a
// valid bit, advancing only when en_i is high.
module sum_pipe_level #(
    parameter int N_LEAF = 2,
    parameter int W      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en_i,
    input  logic                         valid_i,
    input  logic [N_LEAF-1:0][W-1:0]     data_i,
    output logic                         valid_o,
    output logic [N_LEAF/2-1:0][W-1:0]   data_o
);

    logic [N_LEAF/2-1:0][W-1:0] data_d;
    logic [N_LEAF/2-1:0][W-1:0] data_q;
    logic                       valid_q;

    for (genvar gi = 0; gi < N_LEAF / 2; gi++) begin : g_pair
        assign data_d[gi] = data_i[2*gi] + data_i[2*gi+1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (en_i) begin
            data_q  <= data_d;
            valid_q <= valid_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/neuron_sum_pipe.sv
// Pipelined signed adder tree: N_IN inputs plus bias reduced to one
// pre-activation sum, with stall-all valid/ready flow control.
module neuron_sum_pipe
    import neuron_pkg::*;
#(
    parameter int N_IN     = 32,
    parameter int IN_W     = 32,
    parameter int OUT_W    = 64,
    parameter int SATURATE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN-1:0][IN_W-1:0]  in_data,
    input  logic [IN_W-1:0]            in_bias,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_sum,
    output logic                       out_sat
);

    localparam int LVL   = $clog2(N_IN);
    localparam int ACC_W = acc_w(N_IN, IN_W);
    localparam int NLEAF = 2 ** LVL;

    logic                           adv;
    // Heap-ordered tree: node 1 is the root, leaves sit at NLEAF..2*NLEAF-1.
    logic [2*NLEAF-1:1][ACC_W-1:0]  node;
    logic [LVL:0]                   vld;
    logic [LVL-1:0][IN_W-1:0]       bias_q;

    logic signed [ACC_W-1:0]        root_s;
    logic signed [ACC_W-1:0]        bias_s;
    logic signed [ACC_W-1:0]        sum_s;
    logic signed [MAX_W-1:0]        sum_ext;
    clamp_t                         clamp;

    logic                           out_valid_q;
    logic [OUT_W-1:0]               out_sum_q;
    logic [OUT_W-1:0]               out_sum_d;
    logic                           out_sat_q;
    logic                           out_sat_d;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    for (genvar gi = 0; gi < NLEAF; gi++) begin : g_leaf
        if (gi < N_IN) begin : g_real
            assign node[NLEAF+gi] = {{(ACC_W-IN_W){in_data[gi][IN_W-1]}}, in_data[gi]};
        end else begin : g_pad
            assign node[NLEAF+gi] = '0;
        end
    end

    assign vld[0] = in_valid;

    for (genvar gi = 0; gi < LVL; gi++) begin : g_lvl
        localparam int NO = 2 ** (LVL - gi - 1);
        sum_pipe_level #(
            .N_LEAF (2 * NO),
            .W      (ACC_W)
        ) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (adv),
            .valid_i (vld[gi]),
            .data_i  (node[4*NO-1:2*NO]),
            .valid_o (vld[gi+1]),
            .data_o  (node[2*NO-1:NO])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q <= '0;
        end else if (adv) begin
            bias_q[0] <= in_bias;
            for (int i = 1; i < LVL; i++) begin
                bias_q[i] <= bias_q[i-1];
            end
        end
    end

    assign root_s  = node[1];
    assign bias_s  = {{(ACC_W-IN_W){bias_q[LVL-1][IN_W-1]}}, bias_q[LVL-1]};
    assign sum_s   = root_s + bias_s;
    assign sum_ext = MAX_W'(sum_s);
    assign clamp   = sat_clamp(sum_ext, OUT_W);

    always_comb begin
        out_sum_d = sum_ext[OUT_W-1:0];
        out_sat_d = 1'b0;
        if (SATURATE != 0) begin
            out_sum_d = clamp.val[OUT_W-1:0];
            out_sat_d = clamp.sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= vld[LVL];
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_sum_pipe.sv
// Scoreboard bench for neuron_sum_pipe: four parameterisations driven with
// directed vectors, results checked by per-instance monitors.
module tb_neuron_sum_pipe;

    typedef struct {
        longint sum;
        logic   sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic one = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t qd[$];
    exp_t ea, eb, ec, ed;

    // A: N_IN=32, IN_W=32, OUT_W=64, saturating
    logic               a_in_valid = 1'b0;
    logic               a_in_ready;
    logic [31:0][31:0]  a_data = '0;
    logic [31:0]        a_bias = '0;
    logic               a_out_valid;
    logic               a_out_ready = 1'b1;
    logic [63:0]        a_out_sum;
    logic               a_out_sat;

    // B and C share inputs: N_IN=4, IN_W=16, OUT_W=16, saturating / wrapping
    logic               b_in_valid = 1'b0;
    logic               b_in_ready, c_in_ready;
    logic [3:0][15:0]   b_data = '0;
    logic [15:0]        b_bias = '0;
    logic               b_out_valid, c_out_valid;
    logic [15:0]        b_out_sum, c_out_sum;
    logic               b_out_sat, c_out_sat;

    // D: N_IN=5 (padded tree), IN_W=32, OUT_W=64
    logic               d_in_valid = 1'b0;
    logic               d_in_ready;
    logic [4:0][31:0]   d_data = '0;
    logic [31:0]        d_bias = '0;
    logic               d_out_valid;
    logic [63:0]        d_out_sum;
    logic               d_out_sat;

    neuron_sum_pipe #(.N_IN(32), .IN_W(32), .OUT_W(64), .SATURATE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_data), .in_bias(a_bias), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_sum(a_out_sum), .out_sat(a_out_sat));

    neuron_sum_pipe #(.N_IN(4), .IN_W(16), .OUT_W(16), .SATURATE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_data), .in_bias(b_bias), .out_valid(b_out_valid),
        .out_ready(one), .out_sum(b_out_sum), .out_sat(b_out_sat));

    neuron_sum_pipe #(.N_IN(4), .IN_W(16), .OUT_W(16), .SATURATE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(c_in_ready),
        .in_data(b_data), .in_bias(b_bias), .out_valid(c_out_valid),
        .out_ready(one), .out_sum(c_out_sum), .out_sat(c_out_sat));

    neuron_sum_pipe #(.N_IN(5), .IN_W(32), .OUT_W(64), .SATURATE(1)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_data), .in_bias(d_bias), .out_valid(d_out_valid),
        .out_ready(one), .out_sum(d_out_sum), .out_sat(d_out_sat));

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input longint act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: output %0d appeared with nothing outstanding", name, act);
    endtask

    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) unexpected("a_extra", signed'(a_out_sum));
            else begin
                ea = qa.pop_front();
                $display("A out: sum=%0d sat=%0d (want %0d/%0d)", signed'(a_out_sum), a_out_sat, ea.sum, ea.sat);
                check("a_sum", signed'(a_out_sum), ea.sum);
                check("a_sat", longint'(a_out_sat), longint'(ea.sat));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid) begin
            if (qb.size() == 0) unexpected("b_extra", longint'(signed'(b_out_sum)));
            else begin
                eb = qb.pop_front();
                $display("B out: sum=%0d sat=%0d (want %0d/%0d)", signed'(b_out_sum), b_out_sat, eb.sum, eb.sat);
                check("b_sum", longint'(signed'(b_out_sum)), eb.sum);
                check("b_sat", longint'(b_out_sat), longint'(eb.sat));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && c_out_valid) begin
            if (qc.size() == 0) unexpected("c_extra", longint'(signed'(c_out_sum)));
            else begin
                ec = qc.pop_front();
                $display("C out: sum=%0d sat=%0d (want %0d/%0d)", signed'(c_out_sum), c_out_sat, ec.sum, ec.sat);
                check("c_sum", longint'(signed'(c_out_sum)), ec.sum);
                check("c_sat", longint'(c_out_sat), longint'(ec.sat));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && d_out_valid) begin
            if (qd.size() == 0) unexpected("d_extra", signed'(d_out_sum));
            else begin
                ed = qd.pop_front();
                $display("D out: sum=%0d sat=%0d (want %0d/%0d)", signed'(d_out_sum), d_out_sat, ed.sum, ed.sat);
                check("d_sum", signed'(d_out_sum), ed.sum);
                check("d_sat", longint'(d_out_sat), longint'(ed.sat));
            end
        end
    end

    // Drives one A vector (all lanes = v) and returns #1 after the accepting edge.
    task automatic send_a(input logic [31:0] v, input logic [31:0] b, input longint e, input logic s);
        bit done = 0;
        a_data     = {32{v}};
        a_bias     = b;
        a_in_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (a_in_ready) begin
                qa.push_back('{sum: e, sat: s});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        if (!done) unexpected("a_accept_timeout", e);
    endtask

    task automatic send_bc(input logic [3:0][15:0] d, input logic [15:0] b,
                           input longint e_b, input logic s_b, input longint e_c);
        b_data     = d;
        b_bias     = b;
        b_in_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b_in_ready && c_in_ready) begin
            qb.push_back('{sum: e_b, sat: s_b});
            qc.push_back('{sum: e_c, sat: 1'b0});
        end else begin
            n_err++;
            $display("FAIL bc_ready: got %0b/%0b, expected 1/1", b_in_ready, c_in_ready);
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic send_d(input logic [4:0][31:0] d, input logic [31:0] b, input longint e);
        d_data     = d;
        d_bias     = b;
        d_in_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (d_in_ready) qd.push_back('{sum: e, sat: 1'b0});
        else begin
            n_err++;
            $display("FAIL d_ready: got 0, expected 1");
        end
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (qa.size() + qb.size() + qc.size() + qd.size()) != 0; i++)
            @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int idx;
        int acc;
        bit took;
        bit seen;
        logic [63:0] snap;
        logic [4:0][31:0] dv;
        logic [3:0][15:0] bv;

        snap = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(a_out_valid), 0);
        check("rst_out_sum", signed'(a_out_sum), 0);
        check("rst_out_sat", longint'(a_out_sat), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", longint'(a_in_ready), 1);

        // All ones plus bias 1; result lands six cycles after acceptance.
        send_a(32'd1, 32'd1, 33, 1'b0);
        lat = 1;
        while (!a_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("a_latency", lat, 6);
        drain();

        // 33 * -2^31 = -70866960384 = 0xFFFF_FFEF_8000_0000
        send_a(32'h8000_0000, 32'h8000_0000, -64'sd70866960384, 1'b0);
        send_a(-32'sd5, 32'd100, -60, 1'b0);
        drain();

        // 4 * 32767 = 131068 = 0x1FFFC: saturates in B, wraps to 0xFFFC (-4) in C.
        send_bc({4{16'h7FFF}}, 16'd0, 32767, 1'b1, -4);
        // 4 * -32768 = -131072 = -0x20000: saturates in B, wraps to 0 in C.
        send_bc({4{16'h8000}}, 16'd0, -32768, 1'b1, 0);
        bv = '0;
        bv[0] = 16'h7FFF;
        send_bc(bv, 16'd0, 32767, 1'b0, 32767);
        send_bc(bv, 16'd1, 32767, 1'b1, -32768);
        bv[0] = 16'd100; bv[1] = 16'd200; bv[2] = -16'sd50; bv[3] = 16'd7;
        send_bc(bv, 16'd3, 260, 1'b0, 260);
        drain();

        // Padded tree, latency 4.
        dv[0] = 32'd1; dv[1] = 32'd2; dv[2] = 32'd3; dv[3] = 32'd4; dv[4] = 32'd5;
        send_d(dv, -32'sd15, 0);
        lat = 1;
        while (!d_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("d_latency", lat, 4);
        dv[0] = 32'd10; dv[1] = -32'sd20; dv[2] = 32'd30; dv[3] = -32'sd40; dv[4] = 32'd50;
        send_d(dv, 32'd7, 37);
        drain();

        // Backpressure: ten vectors (lanes and bias = k) streamed against a stalled sink.
        a_out_ready = 1'b0;
        idx = 0;
        acc = 0;
        a_data = {32{32'(idx + 1)}};
        a_bias = 32'(idx + 1);
        a_in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            took = a_in_ready;
            if (took) qa.push_back('{sum: 33 * (idx + 1), sat: 1'b0});
            if (c == 8) snap = a_out_sum;
            @(posedge clk);
            #1;
            if (took) begin
                idx++;
                acc++;
                a_data = {32{32'(idx + 1)}};
                a_bias = 32'(idx + 1);
            end
        end
        check("bp_accepted", acc, 6);
        check("bp_in_ready", longint'(a_in_ready), 0);
        check("bp_out_valid", longint'(a_out_valid), 1);
        check("bp_head_sum", signed'(a_out_sum), 33);
        check("bp_stable", signed'(a_out_sum), signed'(snap));
        a_out_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 10; c++) begin
            @(negedge clk);
            took = a_in_ready;
            if (took) qa.push_back('{sum: 33 * (idx + 1), sat: 1'b0});
            @(posedge clk);
            #1;
            if (took) begin
                idx++;
                a_data = {32{32'(idx + 1)}};
                a_bias = 32'(idx + 1);
            end
        end
        a_in_valid = 1'b0;
        check("bp_all_sent", idx, 10);
        drain();

        // Reset while results are in flight and one is held at the output.
        a_out_ready = 1'b0;
        send_a(32'd7, 32'd0, 224, 1'b0);
        send_a(32'd8, 32'd0, 256, 1'b0);
        send_a(32'd9, 32'd0, 288, 1'b0);
        for (int i = 0; i < 20 && !a_out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        qa.delete();
        #1;
        check("mid_rst_valid", longint'(a_out_valid), 0);
        check("mid_rst_sum", signed'(a_out_sum), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (a_out_valid) seen = 1;
        end
        check("mid_rst_no_stale", longint'(seen), 0);
        @(posedge clk);
        #1;
        send_a(32'd3, 32'hFFFF_FFFF, 95, 1'b0);
        drain();

        check("qa_empty", qa.size(), 0);
        check("qb_empty", qb.size(), 0);
        check("qc_empty", qc.size(), 0);
        check("qd_empty", qd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
